// File: rtl/sram_bist_pkg.sv
// rtl/sram_bist_pkg.sv - shared types for the SRAM march BIST
// Purpose: FSM state and march phase encodings, plus the state-to-phase map.
// Ports: none (package).
package sram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W0,
    R0,
    W1,
    R1,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    PH_W0 = 2'd0,
    PH_R0 = 2'd1,
    PH_W1 = 2'd2,
    PH_R1 = 2'd3
  } phase_e;

  // Only the read phases can report a mismatch, so only R0/R1 matter here.
  function automatic phase_e read_phase(input state_e s);
    return (s == R0) ? PH_R0 : PH_R1;
  endfunction

endpackage

// File: rtl/sram_bist_if.sv
// rtl/sram_bist_if.sv - BIST-to-SRAM access bus
// Purpose: bundles the single-port SRAM write/read signals.
// Ports (signals): we, addr, wdata driven by the BIST master; rdata returned
//   combinationally by the SRAM slave from addr.
interface sram_bist_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output we, output addr, output wdata, input rdata);
  modport slave  (input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/sram_bist_addr_gen.sv
// rtl/sram_bist_addr_gen.sv - loadable up/down march address counter
// Purpose: produces the march address; load wins over count.
// Ports: clk, rst (sync, active-high); load, load_val; en (count this cycle);
//   dir (0 = up, 1 = down); addr (registered); last (terminal count for dir).
module sram_bist_addr_gen #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              en,
  input  logic              dir,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_val;
    end else if (en) begin
      addr <= dir ? (addr - ADDR_W'(1)) : (addr + ADDR_W'(1));
    end
  end

  // Terminal count rather than overflow: the FSM reloads before any wrap.
  assign last = dir ? (addr == '0) : (addr == {ADDR_W{1'b1}});

endmodule

// File: rtl/sram_bist.sv
// rtl/sram_bist.sv - 4-phase march BIST initiator for a single-port SRAM
// Purpose: runs W0 up, R0 up, W1 down, R1 down; stops at the first mismatch.
// Ports: clk, rst (sync, active-high); start (1-cycle request, honoured in
//   IDLE/DONE only); mem (sram_bist_if master: we/addr/wdata out, rdata in);
//   busy (march running); done (level, until next accepted start);
//   fail, fail_addr, fail_phase (first mismatch, valid while done=1).
module sram_bist
  import sram_bist_pkg::*;
#(
  parameter int                ADDR_W  = 4,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(8'hA5)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  sram_bist_if.master       mem,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [1:0]        fail_phase
);

  state_e            state_q, state_d;

  logic              ag_load;
  logic [ADDR_W-1:0] ag_load_val;
  logic              ag_en;
  logic              ag_dir;
  logic              ag_last;
  logic [ADDR_W-1:0] addr_q;

  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  phase_e            fail_phase_q, fail_phase_d;

  logic              accept;
  logic              mismatch;

  // Second half of the march walks downwards.
  assign ag_dir = (state_q == W1) || (state_q == R1);

  sram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (ag_load),
    .load_val (ag_load_val),
    .en       (ag_en),
    .dir      (ag_dir),
    .addr     (addr_q),
    .last     (ag_last)
  );

  assign accept   = ((state_q == IDLE) || (state_q == DONE)) && start;
  // rdata is combinational from addr, so the compare lands in the same cycle.
  assign mismatch = ((state_q == R0) && (mem.rdata != PATTERN)) ||
                    ((state_q == R1) && (mem.rdata != ~PATTERN));

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_phase_q <= PH_W0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      fail_addr_q  <= fail_addr_d;
      fail_phase_q <= fail_phase_d;
    end
  end

  // Next-state and address-counter control.
  always_comb begin
    state_d     = state_q;
    ag_load     = 1'b0;
    ag_load_val = '0;
    ag_en       = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = W0;
          ag_load = 1'b1;
        end
      end
      W0: begin
        if (ag_last) begin
          state_d = R0;
          ag_load = 1'b1;
        end else begin
          ag_en = 1'b1;
        end
      end
      R0: begin
        // On a mismatch the address is frozen so it stays visible in DONE.
        if (mismatch) begin
          state_d = DONE;
        end else if (ag_last) begin
          state_d     = W1;
          ag_load     = 1'b1;
          ag_load_val = '1;
        end else begin
          ag_en = 1'b1;
        end
      end
      W1: begin
        if (ag_last) begin
          state_d     = R1;
          ag_load     = 1'b1;
          ag_load_val = '1;
        end else begin
          ag_en = 1'b1;
        end
      end
      R1: begin
        if (mismatch || ag_last) begin
          state_d = DONE;
        end else begin
          ag_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    we_d         = (state_d == W0) || (state_d == W1);
    busy_d       = (state_d == W0) || (state_d == R0) ||
                   (state_d == W1) || (state_d == R1);
    done_d       = (state_d == DONE);
    wdata_d      = wdata_q;
    fail_d       = fail_q;
    fail_addr_d  = fail_addr_q;
    fail_phase_d = fail_phase_q;

    if ((state_d == W0) || (state_d == R0)) begin
      wdata_d = PATTERN;
    end else if ((state_d == W1) || (state_d == R1)) begin
      wdata_d = ~PATTERN;
    end

    if (accept) begin
      fail_d       = 1'b0;
      fail_addr_d  = '0;
      fail_phase_d = PH_W0;
    end else if (mismatch) begin
      fail_d       = 1'b1;
      fail_addr_d  = addr_q;
      fail_phase_d = read_phase(state_q);
    end
  end

  assign mem.we     = we_q;
  assign mem.addr   = addr_q;
  assign mem.wdata  = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign fail_addr  = fail_addr_q;
  assign fail_phase = fail_phase_q;

endmodule

// File: tb/tb_sram_bist.sv
// tb/tb_sram_bist.sv - self-checking bench for sram_bist
module tb_sram_bist;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       fail;
  logic [3:0] fail_addr;
  logic [1:0] fail_phase;

  sram_bist_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  sram_bist #(.ADDR_W(4), .DATA_W(8), .PATTERN(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem        (bus),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .fail_addr  (fail_addr),
    .fail_phase (fail_phase)
  );

  always #5 clk = ~clk;

  // SRAM model: sync write, comb read, optional stuck bits at one address.
  logic [7:0] mem_arr [16];
  logic [7:0] stuck0, stuck1;
  logic [3:0] fault_addr;
  logic [7:0] rd;

  always @(posedge clk) begin
    if (bus.we) mem_arr[bus.addr] <= bus.wdata;
  end

  always_comb begin
    rd = mem_arr[bus.addr];
    if (bus.addr == fault_addr) rd = (rd & ~stuck0) | stuck1;
    bus.rdata = rd;
  end

  // SRAM-side protocol properties.
  a_we_busy : assert property (@(posedge clk) disable iff (rst) bus.we |-> busy);
  a_done_idle : assert property (@(posedge clk) disable iff (rst) done |-> (!busy && !bus.we));
  // A read in R0 follows the W0 write of the same address, so unfaulted data is PATTERN.
  a_w_then_r : assert property (@(posedge clk) disable iff (rst)
    (busy && !bus.we && bus.wdata == 8'hA5 && bus.addr != fault_addr) |-> bus.rdata == 8'hA5);

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    string      name;
    logic [7:0] s0;
    logic [7:0] s1;
    logic [3:0] faddr;
    int         p1;
    int         p2;
    logic       efail;
    logic [3:0] eaddr;
    logic [1:0] ephase;
    int         edone;
  } vec_t;

  vec_t vecs [5];

  // Reference march bus sequence for busy cycle k (1..64).
  task automatic exp_bus(input int k, output logic we, output logic [3:0] a, output logic [7:0] wd);
    if (k <= 16)      begin we = 1'b1; a = 4'(k - 1);       wd = 8'hA5; end
    else if (k <= 32) begin we = 1'b0; a = 4'(k - 17);      wd = 8'hA5; end
    else if (k <= 48) begin we = 1'b1; a = 4'(15 - (k - 33)); wd = 8'h5A; end
    else              begin we = 1'b0; a = 4'(15 - (k - 49)); wd = 8'h5A; end
  endtask

  // Entered just after a rising edge; start is high during cycle 0.
  task automatic run_vec(input int i);
    int first_busy, last_busy, busy_cnt, first_done;
    logic seq_ok;
    logic ewe;
    logic [3:0] ea;
    logic [7:0] ewd;
    stuck0     = vecs[i].s0;
    stuck1     = vecs[i].s1;
    fault_addr = vecs[i].faddr;
    first_busy = -1; last_busy = -1; busy_cnt = 0; first_done = -1;
    seq_ok = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = k;
        last_busy = k;
      end
      if (done && first_done < 0 && k > 0) first_done = k;
      if (k == 1) begin
        check({vecs[i].name, " cleared_fail"}, fail, 0);
        check({vecs[i].name, " cleared_done"}, done, 0);
      end
      if (k >= 1 && k < vecs[i].edone && seq_ok) begin
        exp_bus(k, ewe, ea, ewd);
        if (bus.we !== ewe || bus.addr !== ea || (ewe && bus.wdata !== ewd)) begin
          seq_ok = 1'b0;
          $display("FAIL %s seq cycle %0d: got we=%0b addr=%0h wdata=%0h expected we=%0b addr=%0h wdata=%0h",
                   vecs[i].name, k, bus.we, bus.addr, bus.wdata, ewe, ea, ewd);
        end
      end
      @(posedge clk);
      #1;
      start = ((k + 1) == vecs[i].p1) || ((k + 1) == vecs[i].p2);
    end
    start = 1'b0;
    n_total++;
    if (seq_ok) n_pass++;
    check({vecs[i].name, " first_busy"}, first_busy, 1);
    check({vecs[i].name, " last_busy"}, last_busy, vecs[i].edone - 1);
    check({vecs[i].name, " busy_cnt"}, busy_cnt, vecs[i].edone - 1);
    check({vecs[i].name, " done_cycle"}, first_done, vecs[i].edone);
    check({vecs[i].name, " fail"}, fail, vecs[i].efail);
    check({vecs[i].name, " fail_addr"}, fail_addr, vecs[i].eaddr);
    check({vecs[i].name, " fail_phase"}, fail_phase, vecs[i].ephase);
    check({vecs[i].name, " addr_hold"}, bus.addr, vecs[i].eaddr);
    check({vecs[i].name, " we_done"}, bus.we, 0);
  endtask

  initial begin
    //         name            s0     s1     fa  p1  p2  fail addr ph  done
    vecs[0] = '{"good",        8'h00, 8'h00, 0, -1, -1, 0,   0,   0,  65};
    vecs[1] = '{"b2s0_a3",     8'h04, 8'h00, 3, -1, -1, 1,   3,   1,  21};
    vecs[2] = '{"b3s0_a3",     8'h08, 8'h00, 3, -1, -1, 1,   3,   3,  62};
    vecs[3] = '{"b0s1_a0",     8'h00, 8'h01, 0, -1, -1, 1,   0,   3,  65};
    vecs[4] = '{"good_restart",8'h00, 8'h00, 0,  5, 30, 0,   0,   0,  65};

    for (int a = 0; a < 16; a++) mem_arr[a] = 8'h00;
    stuck0 = 8'h00; stuck1 = 8'h00; fault_addr = 4'd0;
    rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst we", bus.we, 0);
    check("rst addr", bus.addr, 0);
    check("rst wdata", bus.wdata, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst fail", fail, 0);
    check("rst fail_addr", fail_addr, 0);
    check("rst fail_phase", fail_phase, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(i);

    // Reset during W1 at addr 9 (cycle 39), then a full clean march.
    stuck0 = 8'h00; stuck1 = 8'h00;
    start = 1'b1;
    for (int k = 0; k < 41; k++) begin
      @(negedge clk);
      if (k == 39) begin
        check("pre_rst busy", busy, 1);
        check("pre_rst we", bus.we, 1);
        check("pre_rst addr", bus.addr, 9);
      end
      if (k == 40) begin
        check("post_rst we", bus.we, 0);
        check("post_rst busy", busy, 0);
        check("post_rst done", done, 0);
        check("post_rst addr", bus.addr, 0);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      rst = (k + 1 == 39);
    end
    rst = 1'b0;
    run_vec(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
